// File: rtl/key_pkg.sv
// Shared definitions for the key event path: arbiter FSM encoding and default timing.
package key_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned HOLD_DELAY_DEF    = 1000;
  localparam int unsigned REPEAT_PERIOD_DEF = 250;
  localparam int unsigned DROP_W            = 8;

endpackage

// File: rtl/key_repeat_timer.sv
// Per-key press edge detect and hold-to-repeat timer; events are single-cycle strobes.
module key_repeat_timer
  import key_pkg::*;
#(
  parameter int unsigned HOLD_DELAY    = HOLD_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_in,
  input  logic rep_en,
  output logic press_evt,
  output logic rep_evt
);

  localparam int unsigned MAXC = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = $clog2(MAXC);

  logic          key_prev;
  logic          phase_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  assign limit     = phase_next ? CW'(REPEAT_PERIOD - 1) : CW'(HOLD_DELAY - 1);
  assign press_evt = key_prev & ~key_in;
  assign rep_evt   = ~press_evt & ~key_in & rep_en & (cnt == limit);

  // key_prev resets high so a key held through reset yields a press afterwards
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_prev   <= 1'b1;
      phase_next <= 1'b0;
      cnt        <= '0;
    end else begin
      key_prev <= key_in;
      if (press_evt) begin
        cnt        <= '0;
        phase_next <= 1'b0;
      end else if (!key_in && rep_en) begin
        if (cnt == limit) begin
          cnt        <= '0;
          phase_next <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Turns debounced key levels into press/repeat events, serialised round-robin onto one valid/ready stream.
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned IDW           = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned HOLD_DELAY    = HOLD_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N-1:0]      key_in,
  input  logic              rep_en,
  output logic              evt_valid,
  output logic [IDW-1:0]    evt_id,
  output logic              evt_rep,
  input  logic              evt_ready,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              drop_clr
);

  localparam int unsigned NDW  = $clog2(N + 1);
  localparam int unsigned SUMW = DROP_W + 1;

  logic [N-1:0] press_evt;
  logic [N-1:0] rep_evt;

  for (genvar g = 0; g < N; g++) begin : g_timer
    key_repeat_timer #(
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_timer (
      .clk       (clk),
      .nrst      (nrst),
      .key_in    (key_in[g]),
      .rep_en    (rep_en),
      .press_evt (press_evt[g]),
      .rep_evt   (rep_evt[g])
    );
  end

  arb_state_t        state_q, state_d;
  logic [N-1:0]      pending, pend_d;
  logic [N-1:0]      pend_rep, prep_d;
  logic [IDW-1:0]    rr_ptr, rr_next;
  logic [IDW-1:0]    sel, hi_sel, lo_sel;
  logic              hi_found, lo_found;
  logic              sel_rep;
  logic              load;
  logic              clr;
  logic [NDW-1:0]    ndrop;
  logic [SUMW-1:0]   drop_sum;
  logic [DROP_W-1:0] drop_d;

  // Round-robin pick: lowest pending index at/after rr_ptr, else lowest overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    sel_rep  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (pending[i]) begin
        if (!hi_found && (i >= int'(rr_ptr))) begin
          hi_found = 1'b1;
          hi_sel   = IDW'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_sel   = IDW'(i);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == IDW'(i)) sel_rep = pend_rep[i];
    end
    rr_next = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          load    = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new event on the key being loaded this cycle re-arms it rather than dropping
  always_comb begin
    pend_d = pending;
    prep_d = pend_rep;
    ndrop  = '0;
    clr    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      clr = load && (sel == IDW'(i));
      if (clr) pend_d[i] = 1'b0;
      if (press_evt[i] || rep_evt[i]) begin
        if (!pending[i] || clr) begin
          pend_d[i] = 1'b1;
          prep_d[i] = ~press_evt[i];
        end else begin
          ndrop = ndrop + NDW'(1);
        end
      end
    end
    drop_sum = {1'b0, drop_cnt} + SUMW'(ndrop);
    if (drop_clr)              drop_d = '0;
    else if (drop_sum[DROP_W]) drop_d = '1;
    else                       drop_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending   <= '0;
      pend_rep  <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_rep   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pending   <= pend_d;
      pend_rep  <= prep_d;
      drop_cnt  <= drop_d;
      evt_valid <= (state_d == ST_OFFER);
      if (load) begin
        evt_id  <= sel;
        evt_rep <= sel_rep;
        rr_ptr  <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter with N=4, HOLD_DELAY=8, REPEAT_PERIOD=4.
module tb_key_event_arbiter;

  logic       clk;
  logic       nrst;
  logic [3:0] key_in;
  logic       rep_en;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_rep;
  logic       evt_ready;
  logic [7:0] drop_cnt;
  logic       drop_clr;

  key_event_arbiter #(
    .N             (4),
    .IDW           (2),
    .HOLD_DELAY    (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .key_in    (key_in),
    .rep_en    (rep_en),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_rep   (evt_rep),
    .evt_ready (evt_ready),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  typedef struct {
    int id;
    int rep;
    int cyc;   // expected acceptance cycle, -1 = any
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int rep, input int c);
    exp_t e;
    e.id  = id;
    e.rep = rep;
    e.cyc = c;
    q.push_back(e);
  endtask

  // Compares each accepted event against the head of the expectation queue
  always @(negedge clk) begin
    #1;
    if (nrst && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_evt: got id=%0d rep=%0d at cycle %0d, want none",
                 evt_id, evt_rep, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_id", int'(evt_id), e.id);
        chk("evt_rep", int'(evt_rep), e.rep);
        if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d events outstanding, want 0", q.size());
      q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  int t0;

  initial begin
    nrst      = 1'b0;
    key_in    = 4'b1111;
    rep_en    = 1'b1;
    evt_ready = 1'b1;
    drop_clr  = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_rep", int'(evt_rep), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // keys 0 and 3 together, rr_ptr=0
    @(negedge clk);
    key_in = 4'b0110; t0 = cyc;
    push(0, 0, t0 + 2);
    push(3, 0, t0 + 4);
    repeat (3) @(negedge clk);
    key_in = 4'b1111;
    drain();

    // key 0 alone moves rr_ptr to 1
    key_in = 4'b1110; t0 = cyc;
    push(0, 0, t0 + 2);
    repeat (3) @(negedge clk);
    key_in = 4'b1111;
    drain();

    // keys 0 and 3 together, rr_ptr=1
    key_in = 4'b0110; t0 = cyc;
    push(3, 0, t0 + 2);
    push(0, 0, t0 + 4);
    repeat (3) @(negedge clk);
    key_in = 4'b1111;
    drain();

    // short press on key 2, latency check
    key_in = 4'b1011; t0 = cyc;
    push(2, 0, t0 + 2);
    @(negedge clk);
    chk("lat_valid_early", int'(evt_valid), 0);
    @(negedge clk);
    chk("lat_valid", int'(evt_valid), 1);
    chk("lat_id", int'(evt_id), 2);
    @(negedge clk);
    key_in = 4'b1111;
    drain();

    // hold key 1 for 20 cycles with repeat
    key_in = 4'b1101; t0 = cyc;
    push(1, 0, t0 + 2);
    push(1, 1, t0 + 10);
    push(1, 1, t0 + 14);
    push(1, 1, t0 + 18);
    repeat (20) @(negedge clk);
    key_in = 4'b1111;
    drain();

    // same hold with repeat disabled
    rep_en = 1'b0;
    key_in = 4'b1101; t0 = cyc;
    push(1, 0, t0 + 2);
    repeat (20) @(negedge clk);
    key_in = 4'b1111;
    drain();
    rep_en = 1'b1;

    // consumer stalled: press, repeat lands in pending, re-press overruns
    evt_ready = 1'b0;
    key_in = 4'b1110; t0 = cyc;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (s == 10) key_in[0] = 1'b1;
      if (s == 13) key_in[0] = 1'b0;
      if (s == 16) key_in[0] = 1'b1;
      if (s >= 2 && (s % 4) == 2) begin
        chk("stall_valid", int'(evt_valid), 1);
        chk("stall_id", int'(evt_id), 0);
      end
    end
    chk("stall_drop", int'(drop_cnt), 1);
    push(0, 0, -1);
    push(0, 1, -1);
    evt_ready = 1'b1;
    drain();
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    chk("drop_clr", int'(drop_cnt), 0);

    // reset during an offer with keys 1 and 2 held
    rep_en    = 1'b0;
    evt_ready = 1'b0;
    key_in    = 4'b1001;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", int'(evt_valid), 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_id", int'(evt_id), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    evt_ready = 1'b1;
    t0 = cyc;
    push(1, 0, t0 + 2);
    push(2, 0, t0 + 4);
    repeat (5) @(negedge clk);
    key_in = 4'b1111;
    drain();
    rep_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Converts the N debounced, active-low key levels produced by the key debouncer into single-shot key events with hold-to-repeat, and serialises simultaneous events from different keys into one valid/ready event stream using round-robin arbitration. It sits between the debouncer outputs and the maze game logic, which consumes one move per accepted event.

## Interface
- N, 4: number of keys. 1..16.
- IDW, $clog2(N) (min 1): width of evt_id.
- HOLD_DELAY, 1_000: cycles a key must stay pressed after its press edge before the first repeat event. Must be ≥2.
- REPEAT_PERIOD, 250: cycles between subsequent repeat events while the key stays held. Must be ≥2.
- clk  in  1  system clock, single clock domain.
- nrst  in  1  asynchronous active-low reset.
- key_in  in  N  debounced key levels; 0 = pressed, 1 = released.
- rep_en  in  1  1 = hold-to-repeat enabled; 0 = press edges only.
- evt_valid  out  1  event offered.
- evt_id  out  IDW  index of the key the offered event belongs to.
- evt_rep  out  1  1 = offered event is a repeat; 0 = press edge.
- evt_ready  in  1  consumer accepts the offered event when evt_valid && evt_ready.
- drop_cnt  out  8  saturating count of events lost to overrun.
- drop_clr  in  1  synchronous clear of drop_cnt.

## Operation
- key_prev[N] registers key_in every cycle. Press edge on key i: key_prev[i]=1, key_in[i]=0.
- Per-key hold timer: cleared and phase=FIRST on the press edge; increments while key_in[i]=0 and rep_en=1; cleared while released or rep_en=0. In phase FIRST, reaching HOLD_DELAY-1 generates a repeat event, clears the counter and sets phase=NEXT; in phase NEXT, reaching REPEAT_PERIOD-1 does the same.
- pending[i] and pend_rep[i] latch the event. Press or repeat event on key i while pending[i]=1: event dropped, drop_cnt increments (saturates at 255), pending and pend_rep unchanged.
- Release of a key does not cancel its pending event.
- FSM, two states:
  - IDLE: evt_valid=0. If any pending bit is set, select the first set bit at or after rr_ptr (wrapping modulo N), load evt_id/evt_rep, clear that pending bit, set rr_ptr = selected+1 (mod N), go to OFFER.
  - OFFER: evt_valid=1; evt_id and evt_rep held stable. On evt_valid && evt_ready, go to IDLE.
- Same-cycle set and clear of pending[i] (new event on the key being loaded): set wins, no drop.
- drop_clr and a drop in the same cycle: clear wins, drop_cnt=0.

## Timing
- Reset values: evt_valid=0, evt_id=0, evt_rep=0, drop_cnt=0. Internal: state=IDLE, pending=0, rr_ptr=0, timers=0, key_prev all ones. A key held through reset therefore produces a press event after reset release.
- Press latency: key_in[i] falls before edge k → pending set at edge k → evt_valid=1 after edge k+1.
- Throughput: one event per two cycles maximum (one IDLE bubble after each acceptance).
- First repeat sets pending at edge k+HOLD_DELAY; subsequent repeats every REPEAT_PERIOD cycles after that.
- Reset assertion mid-OFFER drops the offered event and all pending events immediately; no handshake is completed.

## Structure
- Shared package/include key_pkg: FSM state encoding (ST_IDLE, ST_OFFER), the default HOLD_DELAY/REPEAT_PERIOD constants, and the drop_cnt width (8).
- One sub-module, key_repeat_timer: per-key edge detect, hold counter and phase, with outputs press_evt and rep_evt. It is instantiated N times in a generate loop. The arbiter, pending registers and FSM stay in the top module.

## Test plan
All scenarios use N=4, HOLD_DELAY=8, REPEAT_PERIOD=4, rep_en=1, evt_ready=1 unless stated.
- Reset release with key_in=4'b1111 → evt_valid=0, drop_cnt=0. Drop key 2 for 3 cycles → exactly one event {id=2, rep=0}, with evt_valid high 2 edges after the fall.
- Hold key 1 for 20 cycles → events {1,0}, then {1,1} at press+8, +12 and +16 cycles. rep_en=0 → only {1,0}.
- Keys 0 and 3 fall in the same cycle with rr_ptr=0 → {0,0} then {3,0}. Repeat the test with rr_ptr=1 → {3,0} then {0,0}.
- evt_ready=0 for 30 cycles while key 0 is pressed, released and pressed again → evt_id=0 held stable, one pending event, drop_cnt=1. Then drop_clr → drop_cnt=0.
- Assert nrst while evt_valid=1 with two keys pending, keys held → evt_valid=0 immediately. After release, press events for both held keys arrive in round-robin order starting at id 0.
